// File: rtl/pwm_pkg.sv
// Shared types and defaults for the dead-time gate driver.
// State encoding and the default dead-time counter width.
package pwm_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_DT    = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_deadtime_dt_counter.sv
// Dead-time down-counter: loaded on interval entry,
// reports expiry on the last cycle of the interval.
module dt_counter
  import pwm_pkg::*;
#(
  parameter int W = DT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/pwm_deadtime.sv
// Half-bridge gate driver with dead-time insertion and sticky fault.
// Optional brake input when PWM_DT_BRAKE_EN is defined.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pwm_in,
  input  logic            enable,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault,
  input  logic            fault_clr,
`ifdef PWM_DT_BRAKE_EN
  input  logic            brake,
`endif
  output logic            out_hi,
  output logic            out_lo,
  output logic            fault_latched,
  output logic            in_dt
);

  state_t st, nxt;
  logic   expire;
  logic   hi_d, lo_d, fl_d, dt_d;
  logic   cnt_load, cnt_clr;
  logic [DT_W-1:0] dt_eff;

`ifdef PWM_DT_BRAKE_EN
  logic brake_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brake_q <= 1'b0;
    end else begin
      brake_q <= brake;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= ST_IDLE;
      out_hi        <= 1'b0;
      out_lo        <= 1'b0;
      fault_latched <= 1'b0;
      in_dt         <= 1'b0;
    end else begin
      st            <= nxt;
      out_hi        <= hi_d;
      out_lo        <= lo_d;
      fault_latched <= fl_d;
      in_dt         <= dt_d;
    end
  end

  always_comb begin
    nxt = st;
    if (fault) begin
      nxt = ST_FAULT;
    end else if (st == ST_FAULT) begin
      if (fault_clr) nxt = ST_IDLE;
    end else if (!enable) begin
      nxt = ST_IDLE;
    end else begin
      unique case (st)
        ST_IDLE: nxt = ST_DT;
`ifdef PWM_DT_BRAKE_EN
        ST_HI: if (!pwm_in || brake) nxt = ST_DT;
        ST_LO: if (!brake && (pwm_in || brake_q))
                 nxt = ST_DT;
        ST_DT: if (expire)
                 nxt = (pwm_in && !brake) ? ST_HI : ST_LO;
`else
        ST_HI: if (!pwm_in) nxt = ST_DT;
        ST_LO: if (pwm_in) nxt = ST_DT;
        ST_DT: if (expire)
                 nxt = pwm_in ? ST_HI : ST_LO;
`endif
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they track st exactly.
  always_comb begin
    hi_d = (nxt == ST_HI);
    lo_d = (nxt == ST_LO);
    fl_d = (nxt == ST_FAULT);
    dt_d = (nxt == ST_DT);
  end

  assign dt_eff   = (dead_time == '0) ? DT_W'(1) : dead_time;
  assign cnt_load = (nxt == ST_DT) && (st != ST_DT);
  assign cnt_clr  = (nxt != ST_DT);

  dt_counter #(
    .W (DT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (dt_eff),
    .expire   (expire)
  );

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed and random checks for pwm_deadtime.
// Output vector compared as {out_hi, out_lo, fault_latched, in_dt}.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic       enable;
  logic [7:0] dead_time;
  logic       fault;
  logic       fault_clr;
  logic       out_hi, out_lo, fault_latched, in_dt;
`ifdef PWM_DT_BRAKE_EN
  logic       brake = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_deadtime #(
    .DT_W (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pwm_in        (pwm_in),
    .enable        (enable),
    .dead_time     (dead_time),
    .fault         (fault),
    .fault_clr     (fault_clr),
`ifdef PWM_DT_BRAKE_EN
    .brake         (brake),
`endif
    .out_hi        (out_hi),
    .out_lo        (out_lo),
    .fault_latched (fault_latched),
    .in_dt         (in_dt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ov();
    return {28'd0, out_hi, out_lo, fault_latched, in_dt};
  endfunction

  initial begin
    reset     = 1'b0;
    pwm_in    = 1'b1;
    enable    = 1'b1;
    dead_time = 8'd4;
    fault     = 1'b0;
    fault_clr = 1'b0;
    #12;
    chk("reset", ov(), 32'h0);
    tick();
    reset = 1'b1;
    #2;
    chk("post_rst_idle", ov(), 32'h0);

    // first output is reached only through a 4-cycle DT
    tick();
    chk("en_to_dt", ov(), 32'h1);
    repeat (3) tick();
    chk("dt4_hold", ov(), 32'h1);
    tick();
    chk("dt4_hi", ov(), 32'h8);

    // hi -> lo with dead_time=4
    pwm_in = 1'b0;
    tick();
    chk("hi_fall", ov(), 32'h1);
    repeat (3) tick();
    chk("lo_wait", ov(), 32'h1);
    tick();
    chk("lo_rise", ov(), 32'h4);

    // dead_time=0 acts as one cycle
    dead_time = 8'd0;
    for (int i = 0; i < 2; i++) begin
      pwm_in = 1'b1;
      tick();
      chk("dt0_gap_a", ov(), 32'h1);
      tick();
      chk("dt0_hi", ov(), 32'h8);
      pwm_in = 1'b0;
      tick();
      chk("dt0_gap_b", ov(), 32'h1);
      tick();
      chk("dt0_lo", ov(), 32'h4);
    end

    // short glitch inside a 10-cycle interval
    dead_time = 8'd10;
    pwm_in = 1'b1;
    tick();
    chk("dt10_in", ov(), 32'h1);
    tick();
    chk("dt10_glitch", ov(), 32'h1);
    pwm_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("dt10_run", ov(), 32'h1);
    end
    tick();
    chk("dt10_lo", ov(), 32'h4);

    // fault handling
    dead_time = 8'd2;
    pwm_in = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_fault_hi", ov(), 32'h8);
    fault = 1'b1;
    tick();
    chk("fault_in", ov(), 32'h2);
    fault = 1'b0;
    tick();
    chk("fault_sticky", ov(), 32'h2);
    fault = 1'b1;
    fault_clr = 1'b1;
    tick();
    chk("fault_clr_blk", ov(), 32'h2);
    fault = 1'b0;
    tick();
    chk("fault_clr", ov(), 32'h0);
    fault_clr = 1'b0;
    tick();
    chk("fault_redt", ov(), 32'h1);
    tick();
    tick();
    chk("fault_rehi", ov(), 32'h8);

    // enable low drops to idle in one cycle
    enable = 1'b0;
    tick();
    chk("en_off", ov(), 32'h0);

    // reset mid-DT with dead_time=200
    dead_time = 8'd200;
    enable = 1'b1;
    tick();
    chk("dt200_in", ov(), 32'h1);
    repeat (5) tick();
    reset = 1'b0;
    #2;
    chk("rst_mid_dt", ov(), 32'h0);
    reset = 1'b1;
    tick();
    chk("dt200_re", ov(), 32'h1);
    dead_time = 8'd3;
    repeat (198) tick();
    chk("dt200_hold", ov(), 32'h1);
    tick();
    tick();
    chk("dt200_hi", ov(), 32'h8);

    // random stress for shoot-through
    for (int i = 0; i < 20000; i++) begin
      pwm_in    = ($urandom_range(0, 3) == 0) ? ~pwm_in : pwm_in;
      enable    = ($urandom_range(0, 49) != 0);
      dead_time = 8'($urandom_range(0, 7));
      fault     = ($urandom_range(0, 499) == 0);
      fault_clr = ($urandom_range(0, 9) == 0);
      tick();
      chk("no_shoot", {31'd0, out_hi & out_lo}, 32'h0);
      chk("fault_off",
          {31'd0, fault_latched & (out_hi | out_lo)}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
